// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
package mem_pkg;

    localparam int unsigned XLEN                = 16;
    localparam int unsigned RIDX_W              = 3;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              excep;
        logic [XLEN-1:0]   epc;
    } wb_result_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for an outstanding data-memory request; expired at TIMEOUT-1.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)      count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + CW'(1);
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: ALU pass-through, req/ack data-memory access, watchdog exception.
// Optional build macro MEM_ALIGN_CHECK_EN faults odd-address loads/stores without a request.
module memory_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_ldst,
    input  logic              ex_store,
    input  logic [XLEN-1:0]   ex_addr,
    input  logic [XLEN-1:0]   ex_data,
    input  logic [RIDX_W-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic [XLEN-1:0]   ex_pc,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_wr,
    output logic [RIDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_excep,
    output logic [XLEN-1:0]   wb_epc
);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [RIDX_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    wb_result_t        wb_q, wb_d;
    logic              ctr_clr, ctr_en, expired;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
            wb_q    <= wb_d;
        end
    end

    // Next state, request latch and writeback result; wb_d defaults to an empty slot.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        wb_d    = '0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (ex_valid) begin
                    if (!ex_ldst) begin
                        wb_d.valid = 1'b1;
                        wb_d.wr    = ex_wr;
                        wb_d.rd    = ex_rd;
                        wb_d.data  = ex_addr;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (ex_addr[0]) begin
                        wb_d.valid = 1'b1;
                        wb_d.excep = 1'b1;
                        wb_d.epc   = ex_pc;
                    end
`endif
                    else begin
                        req_d   = 1'b1;
                        we_d    = ex_store;
                        addr_d  = ex_addr;
                        wdata_d = ex_data;
                        rd_d    = ex_rd;
                        pc_d    = ex_pc;
                        ctr_clr = 1'b1;
                        state_d = MEM_ACCESS;
                    end
                end
            end
            MEM_ACCESS: begin
                // Ack has priority over an expiry in the same cycle.
                if (dmem_ack) begin
                    req_d      = 1'b0;
                    wb_d.valid = 1'b1;
                    wb_d.rd    = rd_q;
                    if (!we_q) begin
                        wb_d.wr   = 1'b1;
                        wb_d.data = dmem_rdata;
                    end
                    state_d = MEM_IDLE;
                end else if (expired) begin
                    req_d      = 1'b0;
                    wb_d.valid = 1'b1;
                    wb_d.excep = 1'b1;
                    wb_d.epc   = pc_q;
                    state_d    = MEM_IDLE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    assign ex_ready   = (state_q == MEM_IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_q.valid;
    assign wb_wr      = wb_q.wr;
    assign wb_rd      = wb_q.rd;
    assign wb_data    = wb_q.data;
    assign wb_excep   = wb_q.excep;
    assign wb_epc     = wb_q.epc;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed stimulus, expected results queued, monitor compares.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_ldst, ex_store, ex_wr;
    logic [15:0] ex_addr, ex_data, ex_pc;
    logic [2:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_wr, wb_excep;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data, wb_epc;

    typedef struct {
        logic        wr;
        logic [2:0]  rd;
        logic [15:0] data;
        logic        excep;
        logic [15:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    memory_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ldst(ex_ldst), .ex_store(ex_store),
        .ex_addr(ex_addr), .ex_data(ex_data), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_pc(ex_pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_excep(wb_excep), .wb_epc(wb_epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic wr, input logic [2:0] rd, input logic [15:0] data,
                                input logic excep, input logic [15:0] epc);
        exp_t e;
        e.wr = wr; e.rd = rd; e.data = data; e.excep = excep; e.epc = epc;
        return e;
    endfunction

    // Monitor: every writeback pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_excep", 32'(wb_excep), 32'(e.excep));
                chk("wb_wr", 32'(wb_wr), 32'(e.wr));
                if (e.excep) chk("wb_epc", 32'(wb_epc), 32'(e.epc));
                if (e.wr) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", 32'(wb_data), 32'(e.data));
                end
            end
        end
    end

    // Called at posedge+1; leaves the instruction transferred at the next edge, returns at edge+1.
    task automatic issue(input logic ldst, input logic store, input logic [15:0] addr,
                         input logic [15:0] data, input logic [2:0] rd, input logic wr,
                         input logic [15:0] pc);
        int n;
        n = 0;
        while (!ex_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("ex_ready_wait", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_ldst = ldst; ex_store = store; ex_addr = addr;
        ex_data = data; ex_rd = rd; ex_wr = wr; ex_pc = pc;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // Counts request cycles, checks request stability, acks so it is sampled ack_after edges in (0 = never).
    task automatic run_access(input int ack_after, input logic [15:0] rdata,
                              input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              output int req_cycles);
        int unstable;
        req_cycles = 0;
        unstable   = 0;
        for (int i = 0; i < 300; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            if (dmem_we !== we || dmem_addr !== addr || (we && dmem_wdata !== wdata)) unstable++;
            if (ack_after > 0 && i == ack_after - 1) begin
                dmem_ack = 1'b1; dmem_rdata = rdata;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        chk("dmem_req_stable", 32'(unstable), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int rc;
        rst = 1'b1; ex_valid = 1'b0; ex_ldst = 1'b0; ex_store = 1'b0; ex_addr = '0;
        ex_data = '0; ex_rd = '0; ex_wr = 1'b0; ex_pc = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU pass-through, back-to-back
        exp_q.push_back(mk(1'b1, 3'd1, 16'h1111, 1'b0, 16'h0));
        exp_q.push_back(mk(1'b1, 3'd2, 16'h2222, 1'b0, 16'h0));
        exp_q.push_back(mk(1'b1, 3'd3, 16'h3333, 1'b0, 16'h0));
        chk("alu_ready0", 32'(ex_ready), 32'd1);
        issue(1'b0, 1'b0, 16'h1111, 16'h0, 3'd1, 1'b1, 16'h0010);
        chk("alu_ready1", 32'(ex_ready), 32'd1);
        chk("alu_wb1", 32'(wb_data), 32'h1111);
        issue(1'b0, 1'b0, 16'h2222, 16'h0, 3'd2, 1'b1, 16'h0012);
        chk("alu_ready2", 32'(ex_ready), 32'd1);
        chk("alu_wb2", 32'(wb_data), 32'h2222);
        issue(1'b0, 1'b0, 16'h3333, 16'h0, 3'd3, 1'b1, 16'h0014);
        chk("alu_wb3", 32'(wb_data), 32'h3333);
        @(posedge clk); #1;
        chk("alu_valid_drop", 32'(wb_valid), 32'd0);

        // Load, ack sampled on the third request cycle
        exp_q.push_back(mk(1'b1, 3'd5, 16'hBEEF, 1'b0, 16'h0));
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 3'd5, 1'b1, 16'h0020);
        chk("ld_ex_ready_low", 32'(ex_ready), 32'd0);
        chk("ld_dmem_addr", 32'(dmem_addr), 32'h0040);
        run_access(3, 16'hBEEF, 1'b0, 16'h0040, 16'h0, rc);
        chk("ld_req_cycles", 32'(rc), 32'd3);

        // Store, immediate ack
        exp_q.push_back(mk(1'b0, 3'd6, 16'h0, 1'b0, 16'h0));
        issue(1'b1, 1'b1, 16'h0010, 16'hA5A5, 3'd6, 1'b0, 16'h0030);
        chk("st_dmem_we", 32'(dmem_we), 32'd1);
        chk("st_dmem_wdata", 32'(dmem_wdata), 32'hA5A5);
        run_access(1, 16'h0, 1'b1, 16'h0010, 16'hA5A5, rc);
        chk("st_req_cycles", 32'(rc), 32'd1);
        chk("st_latency2_valid", 32'(wb_valid), 32'd1);

        // Timeout exception
        exp_q.push_back(mk(1'b0, 3'd0, 16'h0, 1'b1, 16'h0100));
        issue(1'b1, 1'b0, 16'h0080, 16'h0, 3'd4, 1'b1, 16'h0100);
        run_access(0, 16'h0, 1'b0, 16'h0080, 16'h0, rc);
        chk("to_req_cycles", 32'(rc), 32'd16);
        chk("to_excep", 32'(wb_excep), 32'd1);
        chk("to_epc", 32'(wb_epc), 32'h0100);
        chk("to_ex_ready", 32'(ex_ready), 32'd1);

        // Ack on the last watchdog cycle wins
        exp_q.push_back(mk(1'b1, 3'd2, 16'h1234, 1'b0, 16'h0));
        issue(1'b1, 1'b0, 16'h0084, 16'h0, 3'd2, 1'b1, 16'h0104);
        run_access(16, 16'h1234, 1'b0, 16'h0084, 16'h0, rc);
        chk("ack16_req_cycles", 32'(rc), 32'd16);
        chk("ack16_no_excep", 32'(wb_excep), 32'd0);

        // Reset mid-access, then a stale ack
        issue(1'b1, 1'b0, 16'h0090, 16'h0, 3'd7, 1'b1, 16'h0108);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mid_ex_ready", 32'(ex_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stale_ack_wb_valid", 32'(wb_valid), 32'd0);
        chk("stale_ack_ex_ready", 32'(ex_ready), 32'd1);

        // Odd-address load
`ifdef MEM_ALIGN_CHECK_EN
        exp_q.push_back(mk(1'b0, 3'd0, 16'h0, 1'b1, 16'h0200));
        issue(1'b1, 1'b0, 16'h0033, 16'h0, 3'd3, 1'b1, 16'h0200);
        chk("align_no_req", 32'(dmem_req), 32'd0);
        chk("align_excep", 32'(wb_excep), 32'd1);
        chk("align_epc", 32'(wb_epc), 32'h0200);
`else
        exp_q.push_back(mk(1'b1, 3'd3, 16'h7777, 1'b0, 16'h0));
        issue(1'b1, 1'b0, 16'h0033, 16'h0, 3'd3, 1'b1, 16'h0200);
        chk("odd_addr_req", 32'(dmem_req), 32'd1);
        chk("odd_addr_addr", 32'(dmem_addr), 32'h0033);
        run_access(2, 16'h7777, 1'b0, 16'h0033, 16'h0, rc);
        chk("odd_req_cycles", 32'(rc), 32'd2);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of `execute`: takes the ALU result and operands of each retiring instruction, performs the data-memory access for loads/stores over a req/ack handshake, and presents a single registered result to writeback. Non-memory instructions pass through with one cycle of latency. A watchdog counter converts a hung memory access into a precise exception carrying the instruction's PC.

## Interface
- `TIMEOUT`, 16, cycles `dmem_req` may stay high without `dmem_ack` before an exception (2..255)
- `clk` in 1 clock, all logic on rising edge
- `rst` in 1 synchronous, active-high reset
- `ex_valid` in 1 instruction presented by execute
- `ex_ready` out 1 stage accepts this cycle; transfer when `ex_valid & ex_ready`
- `ex_ldst` in 1 instruction is a load or store
- `ex_store` in 1 1 = store, 0 = load (meaningful only with `ex_ldst`)
- `ex_addr` in 16 ALU result: memory address, or result for non-ldst
- `ex_data` in 16 store data
- `ex_rd` in 3 destination register
- `ex_wr` in 1 instruction writes `ex_rd`
- `ex_pc` in 16 instruction PC
- `dmem_req` out 1 access request, held until ack
- `dmem_we` out 1 write enable
- `dmem_addr` out 16 address
- `dmem_wdata` out 16 store data
- `dmem_ack` in 1 access complete this cycle
- `dmem_rdata` in 16 load data, valid with `dmem_ack`
- `wb_valid` out 1 result valid (one-cycle pulse per instruction)
- `wb_wr` out 1 write register file
- `wb_rd` out 3 destination register
- `wb_data` out 16 write data
- `wb_excep` out 1 instruction faulted; `wb_wr` forced 0
- `wb_epc` out 16 PC of faulting instruction

## Operation
- FSM states: IDLE, ACCESS. Reset → IDLE; all outputs 0; counter 0.
- `ex_ready` = (state == IDLE); combinational from state only.
- IDLE, transfer, `ex_ldst`=0: register `wb_data=ex_addr`, `wb_rd`, `wb_wr=ex_wr`, `wb_valid=1`; stay IDLE.
- IDLE, transfer, `ex_ldst`=1: latch addr/data/we/rd/pc; `dmem_req=1`; → ACCESS; counter cleared.
- ACCESS, `dmem_ack`: drop `dmem_req`; `wb_valid=1`; load: `wb_data=dmem_rdata`, `wb_wr=1`; store: `wb_wr=0`; → IDLE.
- ACCESS, no ack: counter++; when counter reaches `TIMEOUT-1` without ack: drop `dmem_req`, `wb_valid=1`, `wb_excep=1`, `wb_epc`=latched PC, `wb_wr=0`; → IDLE.
- Ack and timeout same cycle: ack wins, no exception.
- `dmem_ack` while IDLE (stale/late): ignored.
- `dmem_addr/we/wdata` stable for the whole request.
- `wb_*` are registered; `wb_valid`, `wb_excep` deassert the cycle after a pulse unless a new result is produced.
- Writeback never back-pressures.
- Reset mid-ACCESS: next edge IDLE, `dmem_req=0`, in-flight access abandoned, no `wb_valid`.

## Timing
- Non-ldst: transfer at edge E → `wb_valid` high in cycle after E; back-to-back throughput 1/cycle.
- Ldst: transfer at E0 → `dmem_req` high from E0; ack sampled at edge Ek → `wb_valid` after Ek. Minimum 2 cycles transfer-to-writeback; `ex_ready` low from E0 until Ek.
- Timeout: exception result appears exactly `TIMEOUT` cycles after E0+1 request cycles start, i.e. `dmem_req` high for exactly `TIMEOUT` cycles.
- Counter width `$clog2(TIMEOUT)`; never wraps (cleared on entering ACCESS).

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: ldst with `ex_addr[0]=1` issues no request, stays IDLE, produces `wb_valid=1`, `wb_excep=1`, `wb_epc=ex_pc`, `wb_wr=0` one cycle after transfer.
- Undefined: no check; odd addresses go to memory unchanged.

## Structure
- `mem_pkg`: state enum (`MEM_IDLE`, `MEM_ACCESS`), default timeout constant, writeback result struct (valid, wr, rd, data, excep, epc).
- Sub-module `mem_timeout_ctr`: clear/enable inputs, `expired` output at `TIMEOUT-1`; synchronous reset.

## Test plan
- ALU pass-through: 3 back-to-back non-ldst, `ex_addr`=0x1111/0x2222/0x3333, `ex_wr`=1 → `wb_data` same sequence on 3 consecutive cycles, `ex_ready` always 1.
- Load, ack after 3 cycles, `dmem_rdata`=0xBEEF, `ex_addr`=0x0040, rd=5 → `dmem_req` 3 cycles at addr 0x0040, `wb_data`=0xBEEF, `wb_rd`=5, `wb_wr`=1.
- Store 0xA5A5 to 0x0010, immediate ack → `dmem_we`=1, `dmem_wdata`=0xA5A5, `wb_valid`=1 with `wb_wr`=0, 2-cycle latency.
- Timeout: load, no ack, pc=0x0100 → `dmem_req` exactly 16 cycles, then `wb_excep`=1, `wb_epc`=0x0100; ack on cycle 16 instead → normal load, no exception.
- Reset asserted mid-ACCESS → `dmem_req`=0, `wb_valid`=0, `ex_ready`=1 after the edge; later stale ack ignored.
- `MEM_ALIGN_CHECK_EN`: load at 0x0033, pc=0x0200 → no `dmem_req`, `wb_excep`=1, `wb_epc`=0x0200 next cycle.
